// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the iterative square-root block.
//   state_t : controller states
//   rw_of   : root width for a given operand width, (width+1)/2
//   cnt_w   : width of the iteration counter, never below 1
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int rw_of(input int width);
    return (width + 1) / 2;
  endfunction

  function automatic int cnt_w(input int width);
    int c;
    c = $clog2(rw_of(width));
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sqrt_iter_if.sv
// Operand / result handshake bundle for sqrt_iter.
//   in_valid/in_ready/in_data/in_rnd        : operand channel (producer -> block)
//   out_valid/out_ready/out_root/out_rem/out_sat : result channel (block -> consumer)
//   master : producer/consumer side, slave : the square-root block
interface sqrt_iter_if #(
  parameter int WIDTH = 16
) ();
  import sqrt_pkg::*;

  localparam int RW = rw_of(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_rnd;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_root;
  logic [RW:0]      out_rem;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_rnd, out_ready,
    input  in_ready, out_valid, out_root, out_rem, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_rnd, out_ready,
    output in_ready, out_valid, out_root, out_rem, out_sat
  );

endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root digit iteration, purely combinational.
//   rem_in   : partial remainder (RW+2 bits)
//   root_in  : partial root
//   bits     : next two operand bits, MSB pair first
//   rem_out  : updated partial remainder
//   root_out : partial root with the new digit shifted in
module sqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW+1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    bits,
  output logic [RW+1:0] rem_out,
  output logic [RW-1:0] root_out
);

  logic [RW+1:0] shifted;
  logic [RW+1:0] trial;
  logic          take;

  // Partial remainder never exceeds twice the partial root, so the
  // bits dropped by the shift and the top root bit are always zero here.
  always_comb begin
    shifted  = (rem_in << 2) | (RW+2)'(bits);
    trial    = {root_in, 2'b01};
    take     = (shifted >= trial);
    rem_out  = take ? (shifted - trial) : shifted;
    root_out = RW'({root_in, take});
  end

endmodule

// File: rtl/sqrt_iter.sv
// Multi-cycle unsigned integer square root, one root bit per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : sqrt_iter_if slave (operand in, root/remainder/saturation out)
//   busy       : high whenever the block is not idle
// Floor or round-to-nearest per operand; out_rem is always x - floor(sqrt(x))^2.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  sqrt_iter_if.slave  bus,
  output logic        busy
);

  localparam int RW = rw_of(WIDTH);
  localparam int EW = 2 * RW;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [RW-1:0] ROOT_MAX = '1;

  state_t        state;
  logic [EW-1:0] xs;
  logic [RW+1:0] rem_r;
  logic [RW-1:0] root_r;
  logic [CW-1:0] k;
  logic          rnd_r;

  logic [RW+1:0] rem_nx;
  logic [RW-1:0] root_nx;
  logic          round_up;

  sqrt_step #(.RW(RW)) u_step (
    .rem_in  (rem_r),
    .root_in (root_r),
    .bits    (xs[EW-1 -: 2]),
    .rem_out (rem_nx),
    .root_out(root_nx)
  );

  // rem > root_floor is the integer form of x >= (root_floor + 0.5)^2.
  always_comb round_up = rnd_r & (rem_nx > (RW+2)'(root_nx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      xs            <= '0;
      rem_r         <= '0;
      root_r        <= '0;
      k             <= '0;
      rnd_r         <= 1'b0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_root  <= '0;
      bus.out_rem   <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state        <= CALC;
            xs           <= EW'(bus.in_data);
            rem_r        <= '0;
            root_r       <= '0;
            k            <= CW'(RW - 1);
            rnd_r        <= bus.in_rnd;
            busy         <= 1'b1;
            bus.in_ready <= 1'b0;
          end
        end
        CALC: begin
          rem_r  <= rem_nx;
          root_r <= root_nx;
          xs     <= xs << 2;
          k      <= k - 1'b1;
          if (k == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_rem   <= (RW+1)'(rem_nx);
            if (round_up && (root_nx == ROOT_MAX)) begin
              bus.out_root <= ROOT_MAX;
              bus.out_sat  <= 1'b1;
            end else begin
              bus.out_root <= root_nx + RW'(round_up);
              bus.out_sat  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench for sqrt_iter: directed table, back-pressure and
// mid-operation reset sequences, and a randomized scoreboard sweep over
// several operand widths.
module tb_sqrt_iter;

  localparam int NI = 5;

  function automatic int width_of(input int g);
    case (g)
      0:       return 16;
      1:       return 9;
      2:       return 2;
      3:       return 7;
      default: return 32;
    endcase
  endfunction

  function automatic int rw_i(input int g);
    return (width_of(g) + 1) / 2;
  endfunction

  logic clk = 1'b0;
  logic rst_n;

  logic        vld  [NI];
  logic        rnd  [NI];
  logic        ordy [NI];
  logic [63:0] dat  [NI];
  logic        ir   [NI];
  logic        ov   [NI];
  logic        sat_o[NI];
  logic        bsy  [NI];
  logic [63:0] root_o[NI];
  logic [63:0] rem_o [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = width_of(g);
    sqrt_iter_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = vld[g];
    assign bus.in_rnd    = rnd[g];
    assign bus.out_ready = ordy[g];
    assign bus.in_data   = dat[g][W-1:0];
    assign ir[g]     = bus.in_ready;
    assign ov[g]     = bus.out_valid;
    assign sat_o[g]  = bus.out_sat;
    assign root_o[g] = 64'(bus.out_root);
    assign rem_o[g]  = 64'(bus.out_rem);
    sqrt_iter #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus),
      .busy (bsy[g])
    );
  end

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  // Reference: greedy bit-by-bit search for the largest r with r*r <= x.
  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  task automatic model(input int i, input logic [63:0] x, input logic r,
                       output logic [63:0] root, output logic [63:0] rem, output logic sat);
    logic [63:0] fl, maxr;
    fl   = isqrt(x);
    rem  = x - fl * fl;
    maxr = (64'd1 << rw_i(i)) - 1;
    sat  = 1'b0;
    root = fl;
    if (r && (4 * x >= (2 * fl + 1) * (2 * fl + 1))) begin
      if (fl == maxr) sat = 1'b1;
      else            root = fl + 1;
    end
  endtask

  task automatic run_op(input int i, input logic [63:0] x, input logic r,
                        output logic [63:0] root, output logic [63:0] rem,
                        output logic sat, output int lat);
    int guard;
    guard = 0;
    dat[i] = x; rnd[i] = r; vld[i] = 1'b1; ordy[i] = 1'b1;
    while (!ir[i] && guard < 50) begin @(negedge clk); guard++; end
    if (!ir[i]) fail("accept_wait");
    @(negedge clk);
    vld[i] = 1'b0;
    lat = 0;
    while (!ov[i] && lat < 200) begin @(negedge clk); lat++; end
    if (!ov[i]) fail("result_wait");
    root = root_o[i]; rem = rem_o[i]; sat = sat_o[i];
    @(negedge clk);
  endtask

  typedef struct {
    int          inst;
    logic [63:0] x;
    logic        rnd;
    logic [63:0] root;
    logic [63:0] rem;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [63:0] root;
    logic [63:0] rem;
    logic        sat;
  } exp_t;

  task automatic sweep(input int i, input int nops);
    exp_t        q[$];
    exp_t        e;
    int          sent, got, cyc, extra;
    logic        acc_last;
    logic [63:0] mask, x, er, em;
    logic        es;
    int          w;
    w = width_of(i);
    mask = (64'd1 << w) - 1;
    sent = 0; got = 0; cyc = 0; extra = 0; acc_last = 1'b0;
    vld[i] = 1'b0; ordy[i] = 1'b0;
    while (got < nops && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc_last) vld[i] = 1'b0;
      if (!vld[i] && sent < nops && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 7))
          0:       x = '0;
          1:       x = mask;
          default: x = {$urandom, $urandom} & mask;
        endcase
        dat[i] = x;
        rnd[i] = 1'($urandom_range(0, 1));
        vld[i] = 1'b1;
      end
      ordy[i] = ($urandom_range(0, 3) != 0);
      acc_last = vld[i] && ir[i];
      if (acc_last) begin
        model(i, dat[i], rnd[i], er, em, es);
        q.push_back('{er, em, es});
        sent++;
      end
      if (ov[i] && ordy[i]) begin
        if (q.size() == 0) begin
          check($sformatf("w%0d_dup", w), 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("w%0d_root", w), root_o[i], e.root);
          check($sformatf("w%0d_rem", w), rem_o[i], e.rem);
          check($sformatf("w%0d_sat", w), 64'(sat_o[i]), 64'(e.sat));
        end
        got++;
      end
    end
    check($sformatf("w%0d_count", w), 64'(got), 64'(nops));
    check($sformatf("w%0d_pending", w), 64'(q.size()), 64'd0);
    vld[i] = 1'b0; ordy[i] = 1'b1;
    repeat (rw_i(i) + 5) begin
      @(negedge clk);
      if (ov[i]) extra++;
    end
    check($sformatf("w%0d_extra", w), 64'(extra), 64'd0);
  endtask

  vec_t        vt[12];
  logic [63:0] g_root, g_rem;
  logic        g_sat;
  int          g_lat, guard;

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; rnd[i] = 1'b0; ordy[i] = 1'b1; dat[i] = '0;
    end

    vt[0]  = '{0, 64'd0,          1'b0, 64'd0,     64'd0,      1'b0};
    vt[1]  = '{0, 64'd200,        1'b0, 64'd14,    64'd4,      1'b0};
    vt[2]  = '{0, 64'd65535,      1'b0, 64'd255,   64'd510,    1'b0};
    vt[3]  = '{0, 64'd210,        1'b1, 64'd14,    64'd14,     1'b0};
    vt[4]  = '{0, 64'd211,        1'b1, 64'd15,    64'd15,     1'b0};
    vt[5]  = '{0, 64'd65535,      1'b1, 64'd255,   64'd510,    1'b1};
    vt[6]  = '{0, 64'd65280,      1'b1, 64'd255,   64'd255,    1'b0};
    vt[7]  = '{1, 64'd511,        1'b0, 64'd22,    64'd27,     1'b0};
    vt[8]  = '{1, 64'd511,        1'b1, 64'd23,    64'd27,     1'b0};
    vt[9]  = '{2, 64'd3,          1'b1, 64'd1,     64'd2,      1'b1};
    vt[10] = '{2, 64'd2,          1'b1, 64'd1,     64'd1,      1'b0};
    vt[11] = '{4, 64'hFFFF_FFFF,  1'b0, 64'd65535, 64'd131070, 1'b0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_valid%0d", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst_busy%0d", i), 64'(bsy[i]), 64'd0);
      check($sformatf("rst_root%0d", i), root_o[i], 64'd0);
      check($sformatf("rst_rem%0d", i), rem_o[i], 64'd0);
      check($sformatf("rst_sat%0d", i), 64'(sat_o[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("rst_ready%0d", i), 64'(ir[i]), 64'd1);

    // Directed table
    for (int n = 0; n < 12; n++) begin
      run_op(vt[n].inst, vt[n].x, vt[n].rnd, g_root, g_rem, g_sat, g_lat);
      check($sformatf("v%0d_root", n), g_root, vt[n].root);
      check($sformatf("v%0d_rem", n), g_rem, vt[n].rem);
      check($sformatf("v%0d_sat", n), 64'(g_sat), 64'(vt[n].sat));
      check($sformatf("v%0d_latency", n), 64'(g_lat), 64'(rw_i(vt[n].inst)));
    end

    // Back-pressure: result held 5 cycles while the next operand is offered
    dat[0] = 64'd1000; rnd[0] = 1'b0; vld[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    vld[0] = 1'b0;
    guard = 0;
    while (!ov[0] && guard < 50) begin @(negedge clk); guard++; end
    if (!ov[0]) fail("bp_result_wait");
    check("bp_root", root_o[0], 64'd31);
    check("bp_rem", rem_o[0], 64'd39);
    dat[0] = 64'd150; vld[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(ov[0]), 64'd1);
      check("bp_hold_root", root_o[0], 64'd31);
      check("bp_hold_rem", rem_o[0], 64'd39);
      check("bp_hold_ready", 64'(ir[0]), 64'd0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_after_valid", 64'(ov[0]), 64'd0);
    check("bp_after_ready", 64'(ir[0]), 64'd1);
    check("bp_after_root", root_o[0], 64'd31);
    @(negedge clk);
    check("bp_next_accept", 64'(bsy[0]), 64'd1);
    check("bp_next_ready", 64'(ir[0]), 64'd0);
    vld[0] = 1'b0;
    g_lat = 0;
    while (!ov[0] && g_lat < 200) begin @(negedge clk); g_lat++; end
    check("bp_next_latency", 64'(g_lat), 64'd8);
    check("bp_next_root", root_o[0], 64'd12);
    check("bp_next_rem", rem_o[0], 64'd6);
    @(negedge clk);

    // Reset during iteration 4 of 8
    dat[0] = 64'd40000; rnd[0] = 1'b1; vld[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ov[0]), 64'd0);
    check("mid_rst_busy", 64'(bsy[0]), 64'd0);
    check("mid_rst_root", root_o[0], 64'd0);
    check("mid_rst_rem", rem_o[0], 64'd0);
    check("mid_rst_sat", 64'(sat_o[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(ir[0]), 64'd1);
    check("post_rst_valid", 64'(ov[0]), 64'd0);
    run_op(0, 64'd144, 1'b0, g_root, g_rem, g_sat, g_lat);
    check("post_rst_root", g_root, 64'd12);
    check("post_rst_rem", g_rem, 64'd0);
    check("post_rst_sat", 64'(g_sat), 64'd0);
    check("post_rst_latency", 64'(g_lat), 64'd8);

    // Random sweep over widths 2, 7, 16, 32
    sweep(2, 60);
    sweep(3, 60);
    sweep(0, 60);
    sweep(4, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sqrt_iter.md
# sqrt_iter

Multi-cycle unsigned integer square root with valid/ready handshakes on input and output. Produces one root bit per clock, with floor or round-to-nearest mode selected per operand, plus the exact remainder. Sits in the Root-Mean-Square datapath after the mean-of-squares accumulator. Replaces a single-cycle combinational root whose logic depth does not scale to wide operands.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- RW, (WIDTH+1)/2, root width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  unsigned operand x.
- in_rnd  in  1  rounding mode: 0 = floor, 1 = round to nearest. Sampled with in_data.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_root  out  RW  root.
- out_rem  out  RW+1  remainder, x − floor(√x)², in both modes.
- out_sat  out  1  round mode only: the rounded root exceeded 2^RW−1 and was clamped.
- busy  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, go to CALC and latch x, rnd, and the bit counter k=RW−1.
  - CALC: one restoring digit iteration per cycle.
    - Bring down the next two operand bits (MSB pair first) into the partial remainder.
    - Trial value: (root<<2)|1 aligned to the remainder. If remainder ≥ trial, subtract it and shift 1 into the root; otherwise shift 0.
    - k decrements each cycle. After the k=0 iteration, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- Odd WIDTH: zero-extend x by one MSB to an even width before iterating.
- Width rules:
  - Partial remainder is RW+2 bits, so no overflow is possible.
  - Final remainder is ≤ 2·root, so it fits in RW+1 bits.
- Rounding, applied in the final CALC cycle:
  - round_up = rnd & (rem > root_floor). Exact equivalent of x ≥ (root+0.5)².
  - If root_floor = 2^RW−1 and round_up: out_root = 2^RW−1 and out_sat = 1.
  - Otherwise out_root = root_floor + round_up and out_sat = 0.
- out_root, out_rem and out_sat are registered. They are stable for the whole time out_valid is high, and hold their values after the handshake until the next result.
- in_ready is 0 in CALC and DONE. Operands offered then are not taken and must be held by the producer.
- Async reset, at any time including mid-CALC or during DONE:
  - state = IDLE, in_ready = 1 (from reset deassertion), out_valid = 0, out_root = 0, out_rem = 0, out_sat = 0, busy = 0, internal remainder/root/counter = 0.
  - An in-flight operation is dropped silently.

## Timing
- Accept edge E0 (in_valid & in_ready). CALC iterations occur at edges E1..E_RW. out_valid is high after E_RW, so latency is RW cycles.
- Output handshake at edge Ed (out_valid & out_ready): state is IDLE after Ed, and the next accept is at Ed+1 at the earliest.
- Minimum initiation interval is RW+2 cycles, with out_ready tied high.
- out_ready held low: stay in DONE indefinitely with outputs frozen. No combinational path from out_ready to in_ready.
- in_ready depends only on state (registered path). No input-to-output combinational path.

## Structure
- Package sqrt_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Function rw_of(width) = (width+1)/2.
  - Function cnt_w(width) = $clog2(rw_of(width)), minimum 1.
- Sub-module sqrt_step: purely combinational single digit iteration.
  - Inputs: partial remainder, partial root, next two operand bits.
  - Outputs: next remainder, next root.
  - Reusable for a future unrolled/pipelined variant.
- Top: FSM, counter, operand shift register, rounding/saturation logic, output registers. About 150–250 lines.

## Test plan
1. WIDTH=16, floor: x=0 → root 0, rem 0. x=200 → root 14, rem 4. x=65535 → root 255, rem 510, sat 0. out_valid exactly 8 cycles after each accept.
2. WIDTH=16, round:
   - x=210 → 14, rem 14 (tie boundary, not rounded).
   - x=211 → 15, rem 15.
   - x=65535 → 255, sat 1.
   - x=65280 → 255, sat 0 (floor root 255, rem 255, no round-up).
3. Back-pressure: hold out_ready=0 for 5 cycles in DONE. Outputs and out_valid stay constant, in_ready stays 0 with in_valid=1 offered, and the next operand is accepted on the cycle after the output handshake.
4. Reset mid-operation: assert rst_n=0 at iteration 4 of 8. All outputs go to 0 asynchronously, before the next clock edge. After release, x=144 → root 12, rem 0, with no trace of the aborted operand.
5. WIDTH=9 (odd): x=511 floor → 22, rem 27. Round → 23, sat 0.
6. Random sweep over WIDTH ∈ {2, 7, 16, 32}, random in_valid/out_ready, both modes. Scoreboard checks root² ≤ x < (root+1)² (floor), rem = x − floor², and the round/sat rule. No lost or duplicated transactions.
